// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - handshake and datapath bundle for the Keccak round controller
//
// Signals (direction as seen from the controller, modport slave):
//   in_valid     in   a new 1600-bit state is offered
//   in_ready     out  controller is idle and can take a job
//   in_state     in   initial state, [x][y][z]
//   dp_state_out out  current state register, feeds the external round datapath
//   dp_state_in  in   datapath result for dp_state_out / round_idx
//   round_idx    out  current round, selects the iota constant in the datapath
//   out_valid    out  permuted state available
//   out_ready    in   consumer accepts the result
//   out_state    out  permuted state (same register as dp_state_out)
//   busy         out  controller is not idle
//   abort        in   only when KECCAK_ROUND_CTRL_ABORT_EN is defined
// The master modport is the environment side (source, sink and datapath).
interface keccak_round_ctrl_if #(
  parameter int RIDX_W = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4:0][4:0][63:0]   in_state;
  logic [4:0][4:0][63:0]   dp_state_out;
  logic [4:0][4:0][63:0]   dp_state_in;
  logic [RIDX_W-1:0]       round_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic [4:0][4:0][63:0]   out_state;
  logic                    busy;
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
  logic                    abort;

  modport master (
    output in_valid, in_state, dp_state_in, out_ready, abort,
    input  in_ready, dp_state_out, round_idx, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, dp_state_in, out_ready, abort,
    output in_ready, dp_state_out, round_idx, out_valid, out_state, busy
  );
`else
  modport master (
    output in_valid, in_state, dp_state_in, out_ready,
    input  in_ready, dp_state_out, round_idx, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, dp_state_in, out_ready,
    output in_ready, dp_state_out, round_idx, out_valid, out_state, busy
  );
`endif
endinterface

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - iterative Keccak-f[1600] round sequencer around an external round datapath
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - keccak_round_ctrl_if.slave: in_valid/in_ready/in_state job input,
//          dp_state_out/dp_state_in/round_idx to the combinational round
//          datapath, out_valid/out_ready/out_state result output, busy.
// Parameters:
//   NUM_ROUNDS - rounds per job, 1..24
//   RIDX_W     - width of round_idx
// Build option:
//   KECCAK_ROUND_CTRL_ABORT_EN - adds bus.abort; abort in RUN or DONE returns
//   to IDLE on the next edge, keeping the state register contents.
//
// Latency is NUM_ROUNDS+1 edges from the accept edge: one edge loads the
// state, then one edge per round; the last round's edge also enters DONE.
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int RIDX_W     = 5
) (
  input logic               clk,
  input logic               rst,
  keccak_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [RIDX_W-1:0] LAST_RIDX = RIDX_W'(NUM_ROUNDS - 1);

  fsm_t                  fsm;
  logic [4:0][4:0][63:0] state_reg;
  logic [RIDX_W-1:0]     ridx;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  abort_hit;

`ifdef KECCAK_ROUND_CTRL_ABORT_EN
  assign abort_hit = bus.abort && (fsm != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Handshake flags are registered alongside the FSM so each one always
  // matches the state it describes (in_ready <-> IDLE, out_valid <-> DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      state_reg   <= '0;
      ridx        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort_hit) begin
      // State register deliberately left as-is on abort.
      fsm         <= IDLE;
      ridx        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            fsm        <= RUN;
            state_reg  <= bus.in_state;
            ridx       <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= bus.dp_state_in;
          if (ridx == LAST_RIDX) begin
            // Final round result lands on the same edge that enters DONE.
            fsm         <= DONE;
            ridx        <= '0;
            out_valid_q <= 1'b1;
          end else begin
            ridx <= ridx + RIDX_W'(1);
          end
        end
        DONE: begin
          // Returning to IDLE only; a new job needs a further edge.
          if (bus.out_ready) begin
            fsm         <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          fsm         <= IDLE;
          ridx        <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.round_idx    = ridx;
  assign bus.dp_state_out = state_reg;
  assign bus.out_state    = state_reg;

endmodule

// File: doc/keccak_round_ctrl.md
KECCAK_ROUND_CTRL -- requirements
Module: keccak_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 24, giving the number of permutation rounds per job (legal range 1..24).
REQ-002 The block SHALL have parameter RIDX_W, default 5, giving the width of round_idx.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a new 1600-bit state is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the controller can accept a job.
REQ-007 The block SHALL have port in_state, input, [4:0][4:0][63:0]: initial Keccak state, indexed [x][y][z].
REQ-008 The block SHALL have port dp_state_out, output, [4:0][4:0][63:0]: current state register, driven to the external combinational round datapath (theta/rho/pi/chi/iota).
REQ-009 The block SHALL have port dp_state_in, input, [4:0][4:0][63:0]: round datapath result for dp_state_out and round_idx.
REQ-010 The block SHALL have port round_idx, output, RIDX_W bits: current round number, used by the datapath to select the iota constant.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the permuted state is available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port out_state, output, [4:0][4:0][63:0]: the permuted state, equal to dp_state_out.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); inputs offered outside IDLE are ignored.
REQ-017 In IDLE with in_valid=1: state_reg <= in_state, round_idx <= 0, next state RUN.
REQ-018 In RUN, each cycle: state_reg <= dp_state_in and round_idx <= round_idx+1.
REQ-019 When round_idx==NUM_ROUNDS-1 in RUN, the same edge SHALL load the final dp_state_in, clear round_idx to 0 and move to DONE.
REQ-020 Latency SHALL be exactly NUM_ROUNDS+1 edges, from the accept edge to the edge after which out_valid=1; NUM_ROUNDS=1 gives 2.
REQ-021 In DONE: out_valid=1; state_reg and out_state SHALL be held stable until out_ready=1.
REQ-022 In DONE with out_ready=1, the next state SHALL be IDLE; no new job is accepted on that same edge.
REQ-023 Back-pressure (out_ready=0) SHALL hold DONE indefinitely without state change.
REQ-024 round_idx SHALL never exceed NUM_ROUNDS-1 and SHALL read 0 in IDLE and DONE.
REQ-025 out_valid and in_ready SHALL never both be 1.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, state_reg=0, round_idx=0, out_valid=0, busy=0, in_ready=1 once rst deasserts.
REQ-027 Reset during RUN or DONE SHALL abandon the job; no out_valid is produced for it.

Configuration
REQ-028 With macro KECCAK_ROUND_CTRL_ABORT_EN defined, the block SHALL have an extra input abort (1 bit); abort=1 in RUN or DONE forces IDLE on the next edge with round_idx=0 and out_valid=0, keeps state_reg, and takes priority over all other transitions.
REQ-029 With KECCAK_ROUND_CTRL_ABORT_EN undefined, the abort port and its logic SHALL NOT exist; behaviour SHALL be identical to the abort=0 case.

Verification
REQ-030 All-zero in_state with a reference round datapath -> after 25 edges out_valid=1 and out_state[0][0]=64'hF1258F7940E1DDE7 (Keccak-f[1600] of zero).
REQ-031 Check round_idx sequence during RUN: 0,1,...,23, then 0 in DONE; in_ready=0 for all 25 post-accept cycles.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> out_state and out_valid stable; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 Assert rst at round 12 -> immediately IDLE, state_reg=0; a new job then completes correctly in 25 edges.
REQ-034 Drive in_valid=1 continuously with a changed in_state during RUN -> state_reg unaffected; the second job is accepted only after DONE->IDLE.
REQ-035 With KECCAK_ROUND_CTRL_ABORT_EN: abort=1 at round 5 -> IDLE next edge, no out_valid; without the macro, the build has no abort port.
